dm_subword_mem: RTL and testbench

Byte-addressable data memory for the single-cycle/pipelined MIPS-style core. It supports byte, halfword and word loads/stores, with sign or zero extension on loads. Storage depth and address width are parameters. A valid/ready request port and a registered response port replace the old combinational word-only read. On reset, a hardware clear sequencer zeroes the whole array one word per cycle, and the block signals busy until the sweep is done.

---
 rtl/dm_subword_mem_if.sv | 31 +++
 rtl/dm_subword_mem.sv | 180 ++++++++++++++++++
 tb/tb_dm_subword_mem.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dm_subword_mem_if.sv
// Request/response bundle for dm_subword_mem.
//   req_*  : valid/ready load/store request (byte address, right-aligned store data)
//   rsp_*  : one-cycle response pulse with extended load data and error flags
//   busy   : high while the post-reset clear sweep is running
// Modports: master (requester) and slave (memory).
interface dm_subword_mem_if #(
  parameter int unsigned ADDR_W = 14
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_misalign;
  logic              rsp_oor;
  logic              busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_oor, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_oor, busy
  );
endinterface

// File: rtl/dm_subword_mem.sv
// Byte-addressable data memory with byte/half/word loads and stores.
// Ports:
//   clk   : clock, all state updates on rising edge
//   reset : asynchronous, active-high; restarts the clear sweep
//   bus   : dm_subword_mem_if.slave (request, registered response, busy)
// After reset the array is zeroed one word per cycle; requests are refused
// (req_ready=0) until the sweep completes. Stores commit at the accept edge,
// loads are registered and returned one cycle later.
module dm_subword_mem #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned CLR_W       = 12
) (
  input logic             clk,
  input logic             reset,
  dm_subword_mem_if.slave bus
);

  localparam int unsigned      IdxW     = ADDR_W - 2;
  // One bit wider than the index so a full 2^IdxW depth is representable.
  localparam logic [IdxW:0]    DepthIdx = (IdxW + 1)'(DEPTH_WORDS);
  localparam logic [CLR_W-1:0] ClrLast  = CLR_W'(DEPTH_WORDS - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e           state_q, state_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_misalign_q, rsp_misalign_d;
  logic             rsp_oor_q, rsp_oor_d;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             accept;
  logic [IdxW-1:0]  word_idx;
  logic [1:0]       lane;
  logic             misalign;
  logic             oor;
  logic [31:0]      rd_word;
  logic [31:0]      rd_shift;
  logic [31:0]      load_data;
  logic [31:0]      st_data;
  logic [3:0]       st_be;

  logic             mem_we;
  logic [IdxW-1:0]  mem_widx;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;

  assign accept   = bus.req_valid & (state_q == StIdle);
  assign word_idx = bus.req_addr[ADDR_W-1:2];
  assign lane     = bus.req_addr[1:0];
  assign oor      = {1'b0, word_idx} >= DepthIdx;

  always_comb begin
    misalign = 1'b0;
    case (bus.req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = lane[0];
      2'b10:   misalign = (lane != 2'b00);
      default: misalign = 1'b1;
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rd_word = '0;
    if (!oor) begin
      rd_word = mem_q[word_idx];
    end
    rd_shift  = rd_word >> {lane, 3'b000};
    load_data = rd_word;
    case (bus.req_size)
      2'b00: load_data = bus.req_unsigned ? {24'b0, rd_shift[7:0]}
                                          : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01: load_data = bus.req_unsigned ? {16'b0, rd_shift[15:0]}
                                          : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Store path: replicate the right-aligned data across lanes, pick lanes with byte enables.
  always_comb begin
    st_data = bus.req_wdata;
    st_be   = 4'b1111;
    case (bus.req_size)
      2'b00: begin
        st_data = {4{bus.req_wdata[7:0]}};
        st_be   = 4'b0001 << lane;
      end
      2'b01: begin
        st_data = {2{bus.req_wdata[15:0]}};
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = bus.req_wdata;
        st_be   = 4'b1111;
      end
    endcase
  end

  // Single write port shared by the clear sweep and accepted stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = word_idx;
    mem_wdata = st_data;
    mem_be    = st_be;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_widx  = IdxW'(clr_cnt_q);
      mem_wdata = '0;
      mem_be    = 4'b1111;
    end else begin
      mem_we = accept & bus.req_we & ~misalign & ~oor;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) begin
          mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    rsp_valid_d    = accept;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_misalign_d = rsp_misalign_q;
    rsp_oor_d      = rsp_oor_q;

    case (state_q)
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ClrLast) begin
          state_d = StIdle;
        end
      end
      StIdle:  state_d = StIdle;
      default: state_d = StClear;
    endcase

    if (accept) begin
      rsp_misalign_d = misalign;
      rsp_oor_d      = ~misalign & oor;
      rsp_rdata_d    = (misalign | oor | bus.req_we) ? 32'h0 : load_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StClear;
      clr_cnt_q      <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_misalign_q <= 1'b0;
      rsp_oor_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_misalign_q <= rsp_misalign_d;
      rsp_oor_q      <= rsp_oor_d;
    end
  end

  assign bus.req_ready    = (state_q == StIdle);
  assign bus.busy         = (state_q == StClear);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_misalign = rsp_misalign_q;
  assign bus.rsp_oor      = rsp_oor_q;

endmodule

// File: tb/tb_dm_subword_mem.sv
module tb_dm_subword_mem;
  localparam int unsigned AW = 14;
  localparam int unsigned DW = 3072;
  localparam int unsigned CW = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dm_subword_mem_if #(.ADDR_W(AW)) bus ();

  dm_subword_mem #(
    .ADDR_W      (AW),
    .DEPTH_WORDS (DW),
    .CLR_W       (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int passed = 0;
  logic [7:0] ref_mem [DW*4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < DW * 4; i++) ref_mem[i] = 8'h00;
  endtask

  // Issue one request at the negedge; the response is checked just after the accept edge.
  task automatic do_req(input bit we, input logic [1:0] size, input bit uns, input int addr,
                        input logic [31:0] wdata, input string tag);
    int n;
    bit mis, oor;
    logic [31:0] exp;
    n   = 1 << size;
    mis = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
          (size == 2'd2 && (addr % 4) != 0);
    oor = !mis && (addr / 4 >= DW);
    exp = 32'h0;
    if (!mis && !oor && !we) begin
      for (int i = 0; i < n; i++) exp = exp | (32'(ref_mem[addr + i]) << (8 * i));
      if (!uns && n < 4 && exp[8*n-1]) exp = exp | ~((32'h1 << (8 * n)) - 32'h1);
    end
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr[AW-1:0];
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    chk({tag, "/valid"}, 32'(bus.rsp_valid), 32'h1);
    chk({tag, "/rdata"}, bus.rsp_rdata, exp);
    chk({tag, "/misalign"}, 32'(bus.rsp_misalign), 32'(mis));
    chk({tag, "/oor"}, 32'(bus.rsp_oor), 32'(oor));
    if (we && !mis && !oor) begin
      for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
    end
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "/no_rsp"}, 32'(bus.rsp_valid), 32'h0);
  endtask

  // Called at a negedge right after reset release; a store is held on the bus to show it is ignored.
  task automatic wait_sweep(input string tag);
    int n;
    bit rdy_seen;
    n = 0;
    rdy_seen = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 14'h0BFC;
    bus.req_wdata = 32'hFFFF_FFFF;
    while (bus.busy === 1'b1 && n < 5000) begin
      if (bus.req_ready !== 1'b0) rdy_seen = 1'b1;
      if (bus.rsp_valid !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_valid = 1'b0;
    chk({tag, "/sweep_cycles"}, 32'(n), 32'(DW));
    chk({tag, "/ready_or_rsp_in_clear"}, 32'(rdy_seen), 32'h0);
    chk({tag, "/ready_after"}, 32'(bus.req_ready), 32'h1);
  endtask

  initial begin
    int addr;
    logic [1:0] size;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    model_clear();

    #2;
    chk("rst/busy", 32'(bus.busy), 32'h1);
    chk("rst/ready", 32'(bus.req_ready), 32'h0);
    chk("rst/rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst/rdata", bus.rsp_rdata, 32'h0);
    chk("rst/misalign", 32'(bus.rsp_misalign), 32'h0);
    chk("rst/oor", 32'(bus.rsp_oor), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_sweep("clear1");
    do_req(1'b0, 2'd2, 1'b0, 32'h0BFC, 32'h0, "lw_0bfc");

    // Byte lanes
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, "sw_10");
    do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AB, "sb_12");
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw_10");
    chk("lw_10/const", bus.rsp_rdata, 32'h11AB_3344);
    do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, "lb_12");
    chk("lb_12/const", bus.rsp_rdata, 32'hFFFF_FFAB);
    do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, "lbu_12");
    chk("lbu_12/const", bus.rsp_rdata, 32'h0000_00AB);

    // Halfwords
    do_req(1'b1, 2'd1, 1'b0, 32'h20, 32'h0000_8001, "sh_20");
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_7FFE, "sh_22");
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "lw_20");
    chk("lw_20/const", bus.rsp_rdata, 32'h7FFE_8001);
    do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, "lh_20");
    chk("lh_20/const", bus.rsp_rdata, 32'hFFFF_8001);
    do_req(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, "lhu_20");
    chk("lhu_20/const", bus.rsp_rdata, 32'h0000_8001);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "lh_22");
    chk("lh_22/const", bus.rsp_rdata, 32'h0000_7FFE);
    idle("gap1");
    chk("hold/rdata", bus.rsp_rdata, 32'h0000_7FFE);

    // Errors
    do_req(1'b0, 2'd2, 1'b0, 32'h21, 32'h0, "lw_21_mis");
    chk("lw_21/mis_const", 32'(bus.rsp_misalign), 32'h1);
    do_req(1'b1, 2'd1, 1'b0, 32'h23, 32'h0000_5555, "sh_23_mis");
    do_req(1'b1, 2'd2, 1'b0, 32'h3000, 32'hCAFE_F00D, "sw_3000_oor");
    chk("sw_3000/oor_const", 32'(bus.rsp_oor), 32'h1);
    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, "size11_mis");
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "lw_20_after_err");
    chk("lw_20_after_err/const", bus.rsp_rdata, 32'h7FFE_8001);
    do_req(1'b0, 2'd2, 1'b0, 32'h2FFC, 32'h0, "lw_last_word");

    // Back-to-back store then load to the same word
    idle("gap2");
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, "b2b_sw");
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, "b2b_lw");
    chk("b2b_lw/const", bus.rsp_rdata, 32'hDEAD_BEEF);

    // Randomised traffic against the byte-array model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle("rnd_gap");
      if ($urandom_range(0, 11) == 0) addr = int'($urandom_range(12280, 16383));
      else addr = int'($urandom_range(0, 255));
      size = 2'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom,
             "rnd");
    end

    // Reset mid-operation
    do_req(1'b1, 2'd2, 1'b0, 32'h80, 32'h1234_5678, "pre_rst_sw");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 14'h0080;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk("midrst/rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("midrst/busy", 32'(bus.busy), 32'h1);
    chk("midrst/ready", 32'(bus.req_ready), 32'h0);
    chk("midrst/rdata", bus.rsp_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    wait_sweep("clear2");
    do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, "lw_80_after_rst");
    chk("lw_80_after_rst/const", bus.rsp_rdata, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0BFC, 32'h0, "lw_0bfc_after_rst");
    idle("end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
